// File: rtl/elc_pkg.sv
// Shared definitions for the elevator call-scheduling stage.
// Holds the default floor count, the scheduler state enum, the SCAN direction
// constants and a one-hot test that is used by the scheduler and the bench.
package elc_pkg;

    localparam int unsigned DEFAULT_NUM_FLOORS   = 8;
    localparam int unsigned DEFAULT_DWELL_CYCLES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DWELL = 2'd2
    } sched_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // True when exactly one bit is set (callers zero-extend narrower buses).
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction

endpackage

// File: rtl/elc_scan_pick.sv
// SCAN target selection (purely combinational).
// Ports:
//   pending   in  NUM_FLOORS  outstanding calls, one bit per floor
//   cur_floor in  NUM_FLOORS  one-hot current floor
//   dir       in  1           current SCAN direction (DIR_UP / DIR_DOWN)
//   target    out NUM_FLOORS  one-hot chosen floor (zero when nothing found)
//   new_dir   out 1           direction to adopt if target is dispatched
//   found     out 1           a target exists away from cur_floor
module elc_scan_pick
    import elc_pkg::*;
#(
    parameter int unsigned NUM_FLOORS = DEFAULT_NUM_FLOORS
)
(
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [NUM_FLOORS-1:0] cur_floor,
    input  logic                  dir,
    output logic [NUM_FLOORS-1:0] target,
    output logic                  new_dir,
    output logic                  found
);

    logic [NUM_FLOORS-1:0] below;
    logic [NUM_FLOORS-1:0] above;
    logic [NUM_FLOORS-1:0] up_cand;
    logic [NUM_FLOORS-1:0] dn_cand;
    logic [NUM_FLOORS-1:0] near_up;
    logic [NUM_FLOORS-1:0] near_dn;

    always_comb begin
        // Floors strictly below a one-hot position are (pos - 1); the rest
        // except pos itself are strictly above.
        below   = cur_floor - NUM_FLOORS'(1);
        above   = ~(below | cur_floor);
        up_cand = pending & above;
        dn_cand = pending & below;

        // Nearest above is the lowest set bit of up_cand.
        near_up = up_cand & (~up_cand + NUM_FLOORS'(1));

        // Nearest below is the highest set bit of dn_cand.
        near_dn = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (dn_cand[i]) begin
                near_dn    = '0;
                near_dn[i] = 1'b1;
            end
        end

        target  = '0;
        new_dir = dir;
        found   = 1'b0;
        if (dir == DIR_UP) begin
            if (up_cand != '0) begin
                target = near_up;
                found  = 1'b1;
            end else if (dn_cand != '0) begin
                target  = near_dn;
                new_dir = DIR_DOWN;
                found   = 1'b1;
            end
        end else begin
            if (dn_cand != '0) begin
                target = near_dn;
                found  = 1'b1;
            end else if (up_cand != '0) begin
                target  = near_up;
                new_dir = DIR_UP;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elc_call_scheduler.sv
// Elevator call scheduler: latches call buttons, picks the next floor with a
// SCAN policy, drives the controller's one-hot request and holds a door dwell
// at each served floor.
// Optional feature macro: ELC_FIRE_RECALL_EN (adds input fire_recall).
// Ports:
//   clk           in  1           system clock, rising edge
//   reset         in  1           asynchronous, active-high reset
//   call_btn      in  NUM_FLOORS  call buttons (level or pulse)
//   cur_floor     in  NUM_FLOORS  one-hot current floor from controller
//   complete      in  1           controller arrived at request_floor
//   over_time     in  1           door-open-too-long alert
//   over_weight   in  1           overload alert
//   fire_recall   in  1           (ELC_FIRE_RECALL_EN only) recall to floor 0
//   request_floor out NUM_FLOORS  one-hot target to controller
//   pending       out NUM_FLOORS  outstanding calls
//   sched_dir     out 1           SCAN direction, 1=up 0=down
//   busy          out 1           scheduler not idle
//   floor_err     out 1           sticky: cur_floor was not one-hot
module elc_call_scheduler
    import elc_pkg::*;
#(
    parameter int unsigned NUM_FLOORS   = DEFAULT_NUM_FLOORS,
    parameter int unsigned DWELL_CYCLES = DEFAULT_DWELL_CYCLES
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [NUM_FLOORS-1:0] cur_floor,
    input  logic                  complete,
    input  logic                  over_time,
    input  logic                  over_weight,
`ifdef ELC_FIRE_RECALL_EN
    input  logic                  fire_recall,
`endif
    output logic [NUM_FLOORS-1:0] request_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  sched_dir,
    output logic                  busy,
    output logic                  floor_err
);

    localparam int unsigned CNT_W = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

    sched_state_t          state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [NUM_FLOORS-1:0] pending_d, pending_clr, request_d;
    logic                  dir_d, err_d;
    logic                  alert, cur_bad, frozen;

    logic [NUM_FLOORS-1:0] pick_target;
    logic                  pick_dir, pick_found;

    elc_scan_pick #(.NUM_FLOORS(NUM_FLOORS)) u_pick (
        .pending   (pending),
        .cur_floor (cur_floor),
        .dir       (sched_dir),
        .target    (pick_target),
        .new_dir   (pick_dir),
        .found     (pick_found)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pending       <= '0;
            request_floor <= NUM_FLOORS'(1);
            sched_dir     <= DIR_UP;
            floor_err     <= 1'b0;
            cnt           <= '0;
        end else begin
            state         <= state_d;
            pending       <= pending_d;
            request_floor <= request_d;
            sched_dir     <= dir_d;
            floor_err     <= err_d;
            cnt           <= cnt_d;
        end
    end

    always_comb begin
        alert       = over_time | over_weight;
        cur_bad     = !is_onehot(32'(cur_floor));
        // The live check freezes the FSM on the very edge the fault appears,
        // not one cycle later when floor_err has registered it.
        frozen      = floor_err | cur_bad;
        err_d       = frozen;
        state_d     = state;
        request_d   = request_floor;
        dir_d       = sched_dir;
        cnt_d       = cnt;
        pending_clr = '0;

        if (!frozen) begin
            unique case (state)
                IDLE: begin
                    request_d = cur_floor;
                    if ((pending & cur_floor) != '0) begin
                        pending_clr = cur_floor;
                        cnt_d       = DWELL_LOAD;
                        state_d     = DWELL;
                    end else if (pick_found) begin
                        request_d = pick_target;
                        dir_d     = pick_dir;
                        state_d   = SERVE;
                    end
                end
                SERVE: begin
                    if (!alert && complete && (cur_floor == request_floor)) begin
                        pending_clr = request_floor;
                        cnt_d       = DWELL_LOAD;
                        state_d     = DWELL;
                    end
                end
                DWELL: begin
                    if (!alert) begin
                        if (cnt == '0) begin
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt - CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A clear in this cycle beats a simultaneous press of the same floor.
        pending_d = (pending | call_btn) & ~pending_clr;

`ifdef ELC_FIRE_RECALL_EN
        if (fire_recall) begin
            pending_d = '0;
            if (!frozen) begin
                request_d = NUM_FLOORS'(1);
                cnt_d     = '0;
                state_d   = (cur_floor == NUM_FLOORS'(1)) ? IDLE : SERVE;
            end
        end
`endif
    end

endmodule

// File: tb/tb_elc_call_scheduler.sv
// Self-checking bench for elc_call_scheduler (default build, 8 floors,
// 4-cycle dwell). A floor-index reference model runs alongside the DUT and a
// negedge compare process checks every output each cycle; directed scenarios
// add literal expectations, then a randomized phase exercises the rest.
module tb_elc_call_scheduler;
    import elc_pkg::*;

    localparam int N  = 8;
    localparam int DW = 4;

    logic         clk, reset;
    logic [N-1:0] call_btn, cur_floor;
    logic         complete, over_time, over_weight;
    logic [N-1:0] request_floor, pending;
    logic         sched_dir, busy, floor_err;

    int n_cmp = 0;
    int n_bad = 0;

    elc_call_scheduler #(.NUM_FLOORS(N), .DWELL_CYCLES(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .call_btn      (call_btn),
        .cur_floor     (cur_floor),
        .complete      (complete),
        .over_time     (over_time),
        .over_weight   (over_weight),
        .request_floor (request_floor),
        .pending       (pending),
        .sched_dir     (sched_dir),
        .busy          (busy),
        .floor_err     (floor_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    localparam int AT_REST    = 0;
    localparam int TRAVELLING = 1;
    localparam int DOORS_OPEN = 2;

    int     m_mode;
    bit [7:0] m_pend, m_req;
    bit     m_dir, m_err;
    int     m_left;

    function automatic int floor_of(input logic [7:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Nearest pending floor strictly beyond c in the given direction, or -1.
    function automatic int nearest(input bit [7:0] p, input int c, input bit up);
        if (up) begin
            for (int f = c + 1; f < N; f++) if (p[f]) return f;
        end else begin
            for (int f = c - 1; f >= 0; f--) if (p[f]) return f;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin : model
        bit [7:0] clr;
        int c, t;
        if (reset) begin
            m_mode = AT_REST; m_pend = '0; m_req = 8'h01;
            m_dir = 1'b1; m_err = 1'b0; m_left = 0;
        end else begin
            clr = '0;
            if (!m_err && $countones(cur_floor) == 1) begin
                c = floor_of(cur_floor);
                case (m_mode)
                    AT_REST: begin
                        m_req = cur_floor;
                        if (m_pend[c]) begin
                            clr[c] = 1'b1;
                            m_mode = DOORS_OPEN;
                            m_left = DW;
                        end else begin
                            t = nearest(m_pend, c, m_dir);
                            if (t < 0) begin
                                t = nearest(m_pend, c, !m_dir);
                                if (t >= 0) m_dir = !m_dir;
                            end
                            if (t >= 0) begin
                                m_req  = 8'(1) << t;
                                m_mode = TRAVELLING;
                            end
                        end
                    end
                    TRAVELLING: begin
                        if (!(over_time || over_weight) && complete && cur_floor == m_req) begin
                            clr    = m_req;
                            m_mode = DOORS_OPEN;
                            m_left = DW;
                        end
                    end
                    default: begin
                        if (!(over_time || over_weight)) begin
                            m_left = m_left - 1;
                            if (m_left == 0) m_mode = AT_REST;
                        end
                    end
                endcase
            end else begin
                m_err = 1'b1;
            end
            m_pend = (m_pend | call_btn) & ~clr;
        end
    end

    // ---------------- checking ----------------
    task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cmp("request_floor", request_floor, m_req);
        cmp("pending", pending, m_pend);
        cmp("sched_dir", 8'(sched_dir), 8'(m_dir));
        cmp("busy", 8'(busy), (m_mode != AT_REST) ? 8'd1 : 8'd0);
        cmp("floor_err", 8'(floor_err), 8'(m_err));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic step_toward();
        if (floor_of(request_floor) > floor_of(cur_floor)) cur_floor = cur_floor << 1;
        else cur_floor = cur_floor >> 1;
    endtask

    // Walk the car to request_floor, then pulse complete for one edge.
    task automatic serve_request();
        int guard = 0;
        while (cur_floor != request_floor && guard < 64) begin
            step_toward();
            tick();
            guard++;
        end
        n_cmp++;
        if (guard >= 64) begin
            n_bad++;
            $display("FAIL serve_timeout: car at %h never reached %h", cur_floor, request_floor);
        end
        complete = 1'b1;
        tick();
        complete = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy && guard < 40) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (guard >= 40) begin
            n_bad++;
            $display("FAIL idle_timeout: busy still %0d after %0d cycles", busy, guard);
        end
    endtask

    initial begin
        int err_hold;
        reset = 1'b1; call_btn = '0; cur_floor = 8'h01;
        complete = 1'b0; over_time = 1'b0; over_weight = 1'b0;
        tick(); tick();
        cmp("rst_request", request_floor, 8'h01);
        cmp("rst_pending", pending, 8'h00);
        cmp("rst_busy", 8'(busy), 8'd0);
        cmp("rst_dir", 8'(sched_dir), 8'd1);
        reset = 1'b0;
        tick();

        // 1: single call, dispatch latency, dwell length
        call_btn = 8'h10; tick();
        cmp("t1_pending", pending, 8'h10);
        call_btn = '0; tick();
        cmp("t1_request", request_floor, 8'h10);
        cmp("t1_busy", 8'(busy), 8'd1);
        cmp("t1_dir", 8'(sched_dir), 8'd1);
        cur_floor = 8'h10; complete = 1'b1; tick(); complete = 1'b0;
        cmp("t1_cleared", pending, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("t1_dwell_busy", 8'(busy), 8'd1);
        end
        tick();
        cmp("t1_idle", 8'(busy), 8'd0);

        // 2: SCAN up first, then reverse
        cur_floor = 8'h04; tick();
        call_btn = 8'h41; tick(); call_btn = '0; tick();
        cmp("t2_first", request_floor, 8'h40);
        cmp("t2_model_first", m_req, 8'h40);
        cmp("t2_dir_up", 8'(sched_dir), 8'd1);
        serve_request();
        wait_idle();
        tick();
        cmp("t2_second", request_floor, 8'h01);
        cmp("t2_dir_down", 8'(sched_dir), 8'd0);
        cmp("t2_model_dir", 8'(m_dir), 8'd0);

        // 3: overload freezes the dwell countdown
        serve_request();
        over_weight = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        cmp("t3_frozen_busy", 8'(busy), 8'd1);
        over_weight = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        cmp("t3_still_dwell", 8'(busy), 8'd1);
        tick();
        cmp("t3_idle", 8'(busy), 8'd0);

        // 4: call at the current floor opens doors without dispatch
        cur_floor = 8'h08; tick();
        call_btn = 8'h08; tick(); call_btn = '0; tick();
        cmp("t4_pending", pending, 8'h00);
        cmp("t4_busy", 8'(busy), 8'd1);
        cmp("t4_request", request_floor, 8'h08);
        wait_idle();

        // 5: multi-hot floor freezes FSM until reset
        cur_floor = 8'h0C; call_btn = 8'h02; tick(); call_btn = '0;
        cmp("t5_err", 8'(floor_err), 8'd1);
        cur_floor = 8'h08; tick(); tick();
        cmp("t5_sticky", 8'(floor_err), 8'd1);
        cmp("t5_no_dispatch", 8'(busy), 8'd0);
        cmp("t5_req_held", request_floor, 8'h08);
        reset = 1'b1; tick();
        cmp("t5_err_clr", 8'(floor_err), 8'd0);
        cmp("t5_pend_clr", pending, 8'h00);
        reset = 1'b0; tick();

        // reset mid-SERVE discards everything
        call_btn = 8'h81; tick(); call_btn = '0; tick();
        cmp("rs_busy", 8'(busy), 8'd1);
        reset = 1'b1; tick();
        cmp("rs_pending", pending, 8'h00);
        cmp("rs_request", request_floor, 8'h01);
        cmp("rs_idle", 8'(busy), 8'd0);
        reset = 1'b0; tick();

        // randomized phase
        err_hold = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset       = 1'b0;
            call_btn    = ($urandom_range(0, 5) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
            over_weight = ($urandom_range(0, 24) == 0);
            over_time   = ($urandom_range(0, 30) == 0);
            complete    = 1'b0;
            if (err_hold > 0) begin
                err_hold--;
                if (err_hold == 0) begin
                    reset = 1'b1;
                    cur_floor = 8'h01;
                end
            end else if ($urandom_range(0, 899) == 0) begin
                cur_floor = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h81;
                err_hold = 3;
            end else begin
                if (busy && is_onehot(32'(request_floor)) && cur_floor != request_floor) begin
                    if ($urandom_range(0, 1) == 0) step_toward();
                end else if (busy && cur_floor == request_floor) begin
                    complete = ($urandom_range(0, 2) == 0);
                end else begin
                    complete = ($urandom_range(0, 40) == 0);
                end
                if ($urandom_range(0, 699) == 0) reset = 1'b1;
            end
            tick();
        end
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
